// File: rtl/disparity_pkg.sv
// disparity_pkg
// Shared definitions for the line-code balance monitor.
//   state_e    : window FSM states (ACCUM, EMIT)
//   BYTE_BITS  : bits per byte
//   MAX_COUNT  : largest legal ones-count for one byte
//   DISP_MID   : ones-count of a perfectly balanced byte
package disparity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

    localparam int BYTE_BITS = 8;
    localparam int MAX_COUNT = 8;
    localparam int DISP_MID  = 4;

endpackage

// File: rtl/disparity_sat_add.sv
// disparity_sat_add
// Combinational signed saturating add of an ACC_W-bit accumulator and a
// 5-bit signed per-byte disparity. Clamps to the most positive/negative
// ACC_W-bit value instead of wrapping.
// Ports:
//   acc_i  in  ACC_W  current accumulator (signed)
//   d_i    in  5      per-byte disparity (signed, -8..+8)
//   sum_o  out ACC_W  saturated acc_i + d_i (signed)
module disparity_sat_add #(
    parameter int ACC_W = 8
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [4:0]       d_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic [ACC_W:0] sum_wide;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sum_wide = {acc_i[ACC_W-1], acc_i} + {{(ACC_W-4){d_i[4]}}, d_i};

    always_comb begin
        sum_o = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            if (sum_wide[ACC_W]) begin
                sum_o = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/disparity_window.sv
// disparity_window
// Accumulates per-byte ones-counts over WINDOW bytes and reports the window's
// total ones, saturated signed disparity (ones minus zeros), an out-of-range
// count error flag and an optional imbalance alarm.
// Build option: define DISPARITY_ALARM_EN to build the |disparity| >= THRESH
// comparator; otherwise out_alarm is tied low.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake, one_count[3:0] per byte
//   out_valid/ready result handshake
//   out_ones        total ones in the window
//   out_disparity   signed saturated disparity
//   out_err         some one_count in the window exceeded 8
//   out_alarm       |out_disparity| >= THRESH
//
// state | meaning
// ACCUM | accepting beats, building the window
// EMIT  | window result held until out_ready
module disparity_window
    import disparity_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int ACC_W  = 8,
    parameter int THRESH = 8,
    localparam int OW    = $clog2(8*WINDOW+1),
    localparam int BW    = $clog2(WINDOW)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              one_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OW-1:0]           out_ones,
    output logic signed [ACC_W-1:0] out_disparity,
    output logic                    out_err,
    output logic                    out_alarm
);

    if (WINDOW < 2 || WINDOW > 256) begin : g_bad_window
        $error("disparity_window: WINDOW out of range");
    end
    if (THRESH <= 0 || THRESH >= (2**(ACC_W-1))) begin : g_bad_thresh
        $error("disparity_window: THRESH out of range");
    end

    state_e                  state_q, state_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [OW-1:0]           ones_q, ones_d;
    logic                    err_q, err_d;

    logic                    over;
    logic [3:0]              c;
    logic signed [4:0]       d;
    logic signed [ACC_W-1:0] acc_sum;

    assign over = one_count > 4'(MAX_COUNT);
    assign c    = over ? 4'(MAX_COUNT) : one_count;
    // 2*c - 8 == 2*(c - DISP_MID); range -8..+8 fits 5-bit signed.
    assign d    = signed'({1'b0, c[2:0], 1'b0} + {c[3], 4'b0000} - 5'(2*DISP_MID));

    disparity_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc_i (acc_q),
        .d_i   (d),
        .sum_o (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        acc_d     = acc_q;
        ones_d    = ones_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d  = acc_sum;
                    ones_d = ones_q + OW'(c);
                    err_d  = err_q | over;
                    if (bcnt_q == BW'(WINDOW-1)) begin
                        bcnt_d  = '0;
                        state_d = EMIT;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    ones_d  = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            bcnt_q  <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
        end
    end

    // Accumulators are frozen in EMIT, so they serve directly as the
    // held window result.
    assign out_ones      = ones_q;
    assign out_disparity = acc_q;
    assign out_err       = err_q;

`ifdef DISPARITY_ALARM_EN
    logic [ACC_W-1:0] acc_mag;
    // Unsigned magnitude: the most negative value maps to 2^(ACC_W-1).
    assign acc_mag   = acc_q[ACC_W-1] ? (~acc_q + 1'b1) : acc_q;
    assign out_alarm = acc_mag >= ACC_W'(THRESH);
`else
    assign out_alarm = 1'b0;
`endif

endmodule
